// File: rtl/div_exu_if.sv
// rtl/div_exu_if.sv - issue, redirect and writeback signals of the divide unit
interface div_exu_if #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 6
);
    logic                 en;
    logic [1:0]           divop;
    logic                 word;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [ROB_WIDTH:0]   robIdx;
    logic                 redirect;
    logic [ROB_WIDTH:0]   redirectIdx;
    logic                 busy;
    logic                 div_end;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [XLEN-1:0]      wb_data;
    logic [ROB_WIDTH:0]   wb_robIdx;

    modport master (
        output en, divop, word, rs1_data, rs2_data, robIdx,
        output redirect, redirectIdx, wb_ready,
        input  busy, div_end, wb_valid, wb_data, wb_robIdx
    );

    modport slave (
        input  en, divop, word, rs1_data, rs2_data, robIdx,
        input  redirect, redirectIdx, wb_ready,
        output busy, div_end, wb_valid, wb_data, wb_robIdx
    );
endinterface

// File: rtl/div_exu.sv
// rtl/div_exu.sv - iterative radix-2 integer divider with writeback handshake and redirect kill
module div_exu #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 6
) (
    input  logic      clk,
    input  logic      rst,
    div_exu_if.slave  bus
);
    // Word ops work on the low W bits; for XLEN below 32 this collapses to XLEN
    localparam int W   = (XLEN >= 32) ? 32 : XLEN;
    localparam int WSH = XLEN - W;
    localparam int CW  = $clog2(XLEN + 1);
    // Most-negative value as seen after sign extension, for full and word width
    localparam logic [XLEN-1:0] MIN_X = {XLEN{1'b1}} << (XLEN - 1);
    localparam logic [XLEN-1:0] MIN_W = {XLEN{1'b1}} << (W - 1);

    typedef enum logic [2:0] {IDLE, PRE, CALC, POST, DONE} state_t;

    state_t               state, next_state;
    logic [XLEN-1:0]      a_q, b_q;
    logic [1:0]           op_q;
    logic                 word_q;
    logic [ROB_WIDTH:0]   rob_q;
    logic [XLEN-1:0]      quo, rem, dvsr;
    logic [CW-1:0]        cnt;
    logic                 q_neg, r_neg;
    logic [XLEN-1:0]      data_q;
    logic [ROB_WIDTH:0]   wb_rob_q;
    logic                 end_q;

    // a is older than b, accounting for the wrap flag in the msb
    function automatic logic older(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] b);
        if (a[ROB_WIDTH] == b[ROB_WIDTH])
            return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
        else
            return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
    endfunction

    logic kill_held, kill_issue, accept, wb_fire;
    logic sgn, s1, s2, div_zero, ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, a_sx, a_abs, b_abs, spec_res;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_fix, r_fix, sel, post_res;

    assign kill_held  = bus.redirect && older(bus.redirectIdx, rob_q) && (state != IDLE);
    assign kill_issue = bus.redirect && older(bus.redirectIdx, bus.robIdx);
    assign accept     = (state == IDLE) && bus.en && !kill_issue;
    assign wb_fire    = (state == DONE) && bus.wb_ready;

    // Operand conditioning for PRE: word extension, signs, magnitudes and special cases
    always_comb begin
        sgn      = ~op_q[0];
        a_sx     = word_q ? XLEN'($signed(a_q[W-1:0])) : a_q;
        a_ext    = word_q ? (sgn ? XLEN'($signed(a_q[W-1:0])) : XLEN'(a_q[W-1:0])) : a_q;
        b_ext    = word_q ? (sgn ? XLEN'($signed(b_q[W-1:0])) : XLEN'(b_q[W-1:0])) : b_q;
        s1       = sgn & a_ext[XLEN-1];
        s2       = sgn & b_ext[XLEN-1];
        a_abs    = s1 ? -a_ext : a_ext;
        b_abs    = s2 ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = sgn && (&b_ext) && (a_ext == (word_q ? MIN_W : MIN_X));
        special  = div_zero || ovf;
        if (op_q[1])
            spec_res = div_zero ? a_sx : '0;
        else
            spec_res = div_zero ? '1 : a_sx;
    end

    // One restoring-division step plus the sign fix-up used in POST
    always_comb begin
        rem_sh   = {rem, quo[XLEN-1]};
        diff     = rem_sh - {1'b0, dvsr};
        q_fix    = q_neg ? -quo : quo;
        r_fix    = r_neg ? -rem : rem;
        sel      = op_q[1] ? r_fix : q_fix;
        post_res = word_q ? XLEN'($signed(sel[W-1:0])) : sel;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; a kill overrides every other transition
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = PRE;
            PRE:     next_state = special ? DONE : CALC;
            CALC:    if (cnt == CW'(1)) next_state = POST;
            POST:    next_state = DONE;
            DONE:    if (bus.wb_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (kill_held)
            next_state = IDLE;
    end

    // Operand capture, iteration datapath, result registers and the retire pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            rob_q    <= '0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            data_q   <= '0;
            wb_rob_q <= '0;
            end_q    <= 1'b0;
        end else begin
            // Retire: handshake, kill of a held op, or an op dropped at issue
            end_q <= wb_fire || kill_held || ((state == IDLE) && bus.en && kill_issue);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= bus.rs1_data;
                        b_q    <= bus.rs2_data;
                        op_q   <= bus.divop;
                        word_q <= bus.word;
                        rob_q  <= bus.robIdx;
                    end
                end
                PRE: begin
                    if (special) begin
                        data_q   <= spec_res;
                        wb_rob_q <= rob_q;
                    end else begin
                        // Word dividends are parked in the top bits so 32 shifts consume them
                        quo   <= word_q ? (a_abs << WSH) : a_abs;
                        rem   <= '0;
                        dvsr  <= b_abs;
                        cnt   <= word_q ? CW'(W) : CW'(XLEN);
                        q_neg <= s1 ^ s2;
                        r_neg <= s1;
                    end
                end
                CALC: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                end
                POST: begin
                    data_q   <= post_res;
                    wb_rob_q <= rob_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.wb_valid  = (state == DONE);
    assign bus.wb_data   = data_q;
    assign bus.wb_robIdx = wb_rob_q;
    assign bus.div_end   = end_q;

    // Issuing while an op is held is a protocol error; the request is ignored
    a_no_issue_when_busy: assert property (@(posedge clk) disable iff (!rst) !(bus.en && state != IDLE));

endmodule

// File: tb/tb_div_exu.sv
// tb/tb_div_exu.sv - directed scoreboard bench for div_exu
module tb_div_exu;
    logic clk;
    logic rst;
    int   nchk;
    int   nfail;

    logic [31:0] sb_data[$];
    logic [6:0]  sb_rob[$];

    div_exu_if #(.XLEN(32), .ROB_WIDTH(6)) bus ();

    div_exu #(.XLEN(32), .ROB_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : a;
        case (op)
            2'd0:    return 32'($signed(a) / $signed(b));
            2'd1:    return a / b;
            2'd2:    return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 2;
        return 35;
    endfunction

    // Scoreboard side: compare each accepted writeback against the oldest expectation
    always @(negedge clk) begin
        if (rst && bus.wb_valid && bus.wb_ready) begin
            if (sb_data.size() == 0) begin
                chk("sb_underflow", 64'(sb_data.size()), 64'd1);
            end else begin
                logic [31:0] ed;
                logic [6:0]  er;
                ed = sb_data.pop_front();
                er = sb_rob.pop_front();
                chk("wb_data", 64'(bus.wb_data), 64'(ed));
                chk("wb_robIdx", 64'(bus.wb_robIdx), 64'(er));
            end
        end
    end

    // Issue one op, optionally pulse a redirect at a given cycle, wait for wb_valid and check latency
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] rob, input int redir_at, input logic [6:0] redir_idx);
        int lat;
        sb_data.push_back(model(op, a, b));
        sb_rob.push_back(rob);
        bus.en          = 1'b1;
        bus.divop       = op;
        bus.rs1_data    = a;
        bus.rs2_data    = b;
        bus.robIdx      = rob;
        bus.redirectIdx = redir_idx;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            bus.en       = 1'b0;
            bus.redirect = (lat == redir_at);
        end while (!bus.wb_valid && lat < 100);
        bus.redirect = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat(op, a, b)));
    endtask

    // After the handshake edge: unit idle, one div_end pulse
    task automatic finish_op();
        @(posedge clk); #1;
        chk("div_end_pulse", 64'(bus.div_end), 64'd1);
        chk("idle_after_wb", 64'({bus.busy, bus.wb_valid}), 64'd0);
        @(posedge clk); #1;
        chk("div_end_single", 64'(bus.div_end), 64'd0);
    endtask

    initial begin
        nchk = 0;
        nfail = 0;
        rst = 1'b0;
        bus.en = 1'b0;
        bus.divop = 2'd0;
        bus.word = 1'b0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.robIdx = '0;
        bus.redirect = 1'b0;
        bus.redirectIdx = '0;
        bus.wb_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({bus.busy, bus.div_end, bus.wb_valid}), 64'd0);
        chk("reset_wb_data", 64'(bus.wb_data), 64'd0);
        chk("reset_wb_robIdx", 64'(bus.wb_robIdx), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases
        run_op(2'd1, 32'd100, 32'd7, 7'h01, 0, 7'h00);            finish_op();
        run_op(2'd3, 32'd100, 32'd7, 7'h02, 0, 7'h00);            finish_op();
        run_op(2'd0, -32'sd7, 32'd2, 7'h03, 0, 7'h00);            finish_op();
        run_op(2'd2, -32'sd7, 32'd2, 7'h04, 0, 7'h00);            finish_op();
        run_op(2'd2, 32'd7, -32'sd2, 7'h05, 0, 7'h00);            finish_op();
        run_op(2'd0, 32'd5, 32'd0, 7'h06, 0, 7'h00);              finish_op();
        run_op(2'd2, 32'd5, 32'd0, 7'h07, 0, 7'h00);              finish_op();
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 7'h08, 0, 7'h00); finish_op();
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 7'h09, 0, 7'h00); finish_op();

        // Random operands
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i < 3) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op(2'($urandom_range(0, 3)), ra, rb, 7'(8'h10 + i), 0, 7'h00);
            finish_op();
        end

        // Younger op killed at CALC cycle 10
        bus.en = 1'b1; bus.divop = 2'd1; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3;
        bus.robIdx = {1'b0, 6'd5};
        @(posedge clk); #1;
        bus.en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.redirect = 1'b1;
        bus.redirectIdx = {1'b0, 6'd3};
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        chk("kill_div_end", 64'(bus.div_end), 64'd1);
        chk("kill_idle", 64'({bus.busy, bus.wb_valid}), 64'd0);
        @(posedge clk); #1;
        chk("kill_div_end_single", 64'(bus.div_end), 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (bus.wb_valid) seen = 1'b1;
            end
            chk("kill_no_wb", 64'(seen), 64'd0);
        end

        // Op dropped by a same-cycle killing redirect at issue
        bus.en = 1'b1; bus.robIdx = {1'b0, 6'd7};
        bus.redirect = 1'b1; bus.redirectIdx = {1'b0, 6'd2};
        @(posedge clk); #1;
        bus.en = 1'b0; bus.redirect = 1'b0;
        chk("drop_busy", 64'(bus.busy), 64'd0);
        chk("drop_div_end", 64'(bus.div_end), 64'd1);
        @(posedge clk); #1;
        chk("drop_div_end_single", 64'(bus.div_end), 64'd0);

        // Redirect older than nothing held: op survives (plain and wrap cases)
        run_op(2'd1, 32'd999, 32'd10, {1'b1, 6'd2}, 11, {1'b1, 6'd4});  finish_op();
        run_op(2'd3, 32'd999, 32'd10, {1'b0, 6'd60}, 11, {1'b1, 6'd1}); finish_op();

        // Writeback back-pressure
        bus.wb_ready = 1'b0;
        run_op(2'd0, 32'd1234, -32'sd5, 7'h2A, 0, 7'h00);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_wb_data", 64'(bus.wb_data), 64'(model(2'd0, 32'd1234, -32'sd5)));
            chk("stall_rob", 64'(bus.wb_robIdx), 64'h2A);
            chk("stall_busy_valid", 64'({bus.busy, bus.wb_valid, bus.div_end}), 64'b110);
        end
        bus.wb_ready = 1'b1;
        finish_op();

        // Asynchronous reset mid-CALC, then a fresh op
        bus.en = 1'b1; bus.divop = 2'd1; bus.rs1_data = 32'd77; bus.rs2_data = 32'd4;
        bus.robIdx = 7'h11;
        @(posedge clk); #1;
        bus.en = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_flags", 64'({bus.busy, bus.div_end, bus.wb_valid}), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
        chk("rst_wb_robIdx", 64'(bus.wb_robIdx), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_div_end", 64'(bus.div_end), 64'd0);
        run_op(2'd1, 32'd77, 32'd4, 7'h12, 0, 7'h00); finish_op();

        chk("sb_empty", 64'(sb_data.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
